// File: rtl/frame_cmd_ctrl_pkg.sv
// Shared definitions for the UART frame command controller: FSM states,
// command byte codes and the error byte sent back on a bad frame.
package frame_cmd_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        OPA,
        OPB,
        FUN,
        CALC,
        TX_RES,
        ERR_TX
    } state_t;

    // Command and status codes; the top zero-extends them to its byte width.
    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
    localparam logic [7:0] ERR_CODE    = 8'hEE;

    // States that are waiting on the host for another byte and therefore
    // guard against a stalled frame with the inter-byte timeout.
    function automatic logic is_timed(input state_t s);
        return (s == WR_ADDR) || (s == WR_DATA) || (s == RD_ADDR) ||
               (s == OPA)     || (s == OPB)     || (s == FUN);
    endfunction

endpackage

// File: rtl/frame_cmd_ctrl_cmd_timeout.sv
// Inter-byte timeout counter. Held at zero by i_clear, counts while enabled,
// and flags o_expired in the TIMEOUT_CYC-th enabled cycle since the last clear.
module cmd_timeout #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    // Cycle counter: restart on clear, saturate at the last count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: flops take non-blocking assignments so every register in the
        // design samples pre-edge values, independent of block ordering.
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != CNT_LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_enable && (r_cnt == CNT_LAST);

endmodule

// File: rtl/frame_cmd_ctrl.sv
// UART frame command controller: decodes write / read / ALU command frames
// arriving byte by byte, drives the register file and ALU, and streams read
// data, ALU results or an error byte to the TX FIFO. All outputs are registered.
module frame_cmd_ctrl
    import frame_cmd_ctrl_pkg::*;
#(
    parameter int D_WIDTH     = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int FUNC_WIDTH  = 4,
    parameter int RES_BYTES   = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [D_WIDTH-1:0]             RX_DATA,
    input  logic                           RX_VLD,
    input  logic [D_WIDTH-1:0]             RF_RD_DATA,
    input  logic                           RF_RD_VLD,
    input  logic [RES_BYTES*D_WIDTH-1:0]   ALU_OUT,
    input  logic                           ALU_OUT_VLD,
    input  logic                           FIFO_FULL,
    output logic [ADDR_WIDTH-1:0]          RF_ADDR,
    output logic                           RF_WR_EN,
    output logic                           RF_RD_EN,
    output logic [D_WIDTH-1:0]             RF_WR_DATA,
    output logic                           ALU_EN,
    output logic [FUNC_WIDTH-1:0]          ALU_FUN,
    output logic                           CLKG_EN,
    output logic                           CLKDIV_EN,
    output logic [D_WIDTH-1:0]             TX_DATA,
    output logic                           TX_VLD,
    output logic                           ERR
);

    localparam int                   RES_W    = RES_BYTES * D_WIDTH;
    localparam int                   IDX_W    = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(RES_BYTES - 1);
    localparam logic [D_WIDTH-1:0]   C_WR     = D_WIDTH'(CMD_WR);
    localparam logic [D_WIDTH-1:0]   C_RD     = D_WIDTH'(CMD_RD);
    localparam logic [D_WIDTH-1:0]   C_OP     = D_WIDTH'(CMD_ALU_OP);
    localparam logic [D_WIDTH-1:0]   C_NOP    = D_WIDTH'(CMD_ALU_NOP);
    localparam logic [D_WIDTH-1:0]   C_ERR    = D_WIDTH'(ERR_CODE);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_rf_addr;
    logic                  r_rf_wr_en;
    logic                  r_rf_rd_en;
    logic [D_WIDTH-1:0]    r_rf_wr_data;
    logic                  r_alu_en;
    logic [FUNC_WIDTH-1:0] r_alu_fun;
    logic                  r_clkg_en;
    logic                  r_clkdiv_en;
    logic [D_WIDTH-1:0]    r_tx_data;
    logic                  r_tx_vld;
    logic                  r_err;
    logic [RES_W-1:0]      r_alu_res;
    logic                  r_rd_hold;
    logic [IDX_W-1:0]      r_byte_idx;

    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_rf_addr_nxt;
    logic                  w_rf_wr_en_nxt;
    logic                  w_rf_rd_en_nxt;
    logic [D_WIDTH-1:0]    w_rf_wr_data_nxt;
    logic                  w_alu_en_nxt;
    logic [FUNC_WIDTH-1:0] w_alu_fun_nxt;
    logic                  w_clkg_en_nxt;
    logic [D_WIDTH-1:0]    w_tx_data_nxt;
    logic                  w_tx_vld_nxt;
    logic                  w_err_nxt;
    logic [RES_W-1:0]      w_alu_res_nxt;
    logic                  w_rd_hold_nxt;
    logic [IDX_W-1:0]      w_byte_idx_nxt;
    logic                  w_to_clear;
    logic                  w_to_enable;
    logic                  w_expired;

    // The counter idles at zero outside timed states, so entering one starts
    // a fresh window; every accepted byte restarts it.
    assign w_to_enable = is_timed(r_state);
    assign w_to_clear  = RX_VLD || !w_to_enable;

    cmd_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_cmd_timeout (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_clear   (w_to_clear),
        .i_enable  (w_to_enable),
        .o_expired (w_expired)
    );

    // Next-state and next-output decode; a byte always beats a timeout.
    always_comb begin
        // NOTE: every target gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        w_state_nxt      = r_state;
        w_rf_addr_nxt    = r_rf_addr;
        w_rf_wr_en_nxt   = 1'b0;
        w_rf_wr_data_nxt = r_rf_wr_data;
        w_alu_fun_nxt    = r_alu_fun;
        w_alu_res_nxt    = r_alu_res;
        w_tx_data_nxt    = r_tx_data;
        w_tx_vld_nxt     = 1'b0;
        w_err_nxt        = 1'b0;
        w_rd_hold_nxt    = r_rd_hold;
        w_byte_idx_nxt   = r_byte_idx;

        unique case (r_state)
            IDLE: begin
                w_rd_hold_nxt  = 1'b0;
                w_byte_idx_nxt = '0;
                if (RX_VLD) begin
                    if      (RX_DATA == C_WR)  w_state_nxt = WR_ADDR;
                    else if (RX_DATA == C_RD)  w_state_nxt = RD_ADDR;
                    else if (RX_DATA == C_OP)  w_state_nxt = OPA;
                    else if (RX_DATA == C_NOP) w_state_nxt = FUN;
                    else                       w_state_nxt = ERR_TX;
                end
            end
            WR_ADDR: begin
                if (RX_VLD) begin
                    w_rf_addr_nxt = RX_DATA[ADDR_WIDTH-1:0];
                    w_state_nxt   = WR_DATA;
                end else if (w_expired) begin
                    w_state_nxt = ERR_TX;
                end
            end
            WR_DATA: begin
                if (RX_VLD) begin
                    w_rf_wr_data_nxt = RX_DATA;
                    w_rf_wr_en_nxt   = 1'b1;
                    w_state_nxt      = IDLE;
                end else if (w_expired) begin
                    w_state_nxt = ERR_TX;
                end
            end
            RD_ADDR: begin
                if (RX_VLD) begin
                    w_rf_addr_nxt = RX_DATA[ADDR_WIDTH-1:0];
                    w_state_nxt   = RD_WAIT;
                end else if (w_expired) begin
                    w_state_nxt = ERR_TX;
                end
            end
            RD_WAIT: begin
                // The read byte is parked in the TX data register until the
                // FIFO has room.
                if (!r_rd_hold) begin
                    if (RF_RD_VLD) begin
                        w_tx_data_nxt = RF_RD_DATA;
                        w_rd_hold_nxt = 1'b1;
                    end
                end else if (!FIFO_FULL) begin
                    w_tx_vld_nxt = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            OPA: begin
                if (RX_VLD) begin
                    w_rf_addr_nxt    = '0;
                    w_rf_wr_data_nxt = RX_DATA;
                    w_rf_wr_en_nxt   = 1'b1;
                    w_state_nxt      = OPB;
                end else if (w_expired) begin
                    w_state_nxt = ERR_TX;
                end
            end
            OPB: begin
                if (RX_VLD) begin
                    w_rf_addr_nxt    = ADDR_WIDTH'(1);
                    w_rf_wr_data_nxt = RX_DATA;
                    w_rf_wr_en_nxt   = 1'b1;
                    w_state_nxt      = FUN;
                end else if (w_expired) begin
                    w_state_nxt = ERR_TX;
                end
            end
            FUN: begin
                if (RX_VLD) begin
                    w_alu_fun_nxt = RX_DATA[FUNC_WIDTH-1:0];
                    w_state_nxt   = CALC;
                end else if (w_expired) begin
                    w_state_nxt = ERR_TX;
                end
            end
            CALC: begin
                if (ALU_OUT_VLD) begin
                    w_alu_res_nxt  = ALU_OUT;
                    w_byte_idx_nxt = '0;
                    w_state_nxt    = TX_RES;
                end
            end
            TX_RES: begin
                if (!FIFO_FULL) begin
                    w_tx_data_nxt = r_alu_res[int'(r_byte_idx)*D_WIDTH +: D_WIDTH];
                    w_tx_vld_nxt  = 1'b1;
                    if (r_byte_idx == LAST_IDX) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_byte_idx_nxt = r_byte_idx + 1'b1;
                    end
                end
            end
            ERR_TX: begin
                if (!FIFO_FULL) begin
                    w_tx_data_nxt = C_ERR;
                    w_tx_vld_nxt  = 1'b1;
                    w_err_nxt     = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Level outputs follow the state being entered, so once registered
        // they line up exactly with the state they belong to.
        w_rf_rd_en_nxt = (w_state_nxt == RD_WAIT) && !w_rd_hold_nxt;
        w_alu_en_nxt   = (w_state_nxt == CALC);
        w_clkg_en_nxt  = (w_state_nxt == FUN) || (w_state_nxt == CALC) ||
                         (w_state_nxt == TX_RES);
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Output and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rf_addr    <= '0;
            r_rf_wr_en   <= 1'b0;
            r_rf_rd_en   <= 1'b0;
            r_rf_wr_data <= '0;
            r_alu_en     <= 1'b0;
            r_alu_fun    <= '0;
            r_clkg_en    <= 1'b0;
            r_clkdiv_en  <= 1'b1;
            r_tx_data    <= '0;
            r_tx_vld     <= 1'b0;
            r_err        <= 1'b0;
            r_alu_res    <= '0;
            r_rd_hold    <= 1'b0;
            r_byte_idx   <= '0;
        end else begin
            r_rf_addr    <= w_rf_addr_nxt;
            r_rf_wr_en   <= w_rf_wr_en_nxt;
            r_rf_rd_en   <= w_rf_rd_en_nxt;
            r_rf_wr_data <= w_rf_wr_data_nxt;
            r_alu_en     <= w_alu_en_nxt;
            r_alu_fun    <= w_alu_fun_nxt;
            r_clkg_en    <= w_clkg_en_nxt;
            r_clkdiv_en  <= 1'b1;
            r_tx_data    <= w_tx_data_nxt;
            r_tx_vld     <= w_tx_vld_nxt;
            r_err        <= w_err_nxt;
            r_alu_res    <= w_alu_res_nxt;
            r_rd_hold    <= w_rd_hold_nxt;
            r_byte_idx   <= w_byte_idx_nxt;
        end
    end

    assign RF_ADDR    = r_rf_addr;
    assign RF_WR_EN   = r_rf_wr_en;
    assign RF_RD_EN   = r_rf_rd_en;
    assign RF_WR_DATA = r_rf_wr_data;
    assign ALU_EN     = r_alu_en;
    assign ALU_FUN    = r_alu_fun;
    assign CLKG_EN    = r_clkg_en;
    assign CLKDIV_EN  = r_clkdiv_en;
    assign TX_DATA    = r_tx_data;
    assign TX_VLD     = r_tx_vld;
    assign ERR        = r_err;

endmodule

// File: tb/tb_frame_cmd_ctrl.sv
// Directed bench for frame_cmd_ctrl: write, read with FIFO back-pressure,
// ALU frames, timeout and byte-vs-timeout boundary, bad command, mid-frame reset.
module tb_frame_cmd_ctrl;

    localparam int D_WIDTH     = 8;
    localparam int ADDR_WIDTH  = 4;
    localparam int FUNC_WIDTH  = 4;
    localparam int RES_BYTES   = 2;
    localparam int TIMEOUT_CYC = 1024;

    logic                         CLK = 1'b0;
    logic                         RST = 1'b1;
    logic [D_WIDTH-1:0]           RX_DATA = '0;
    logic                         RX_VLD = 1'b0;
    logic [D_WIDTH-1:0]           RF_RD_DATA = '0;
    logic                         RF_RD_VLD = 1'b0;
    logic [RES_BYTES*D_WIDTH-1:0] ALU_OUT = '0;
    logic                         ALU_OUT_VLD = 1'b0;
    logic                         FIFO_FULL = 1'b0;
    logic [ADDR_WIDTH-1:0]        RF_ADDR;
    logic                         RF_WR_EN;
    logic                         RF_RD_EN;
    logic [D_WIDTH-1:0]           RF_WR_DATA;
    logic                         ALU_EN;
    logic [FUNC_WIDTH-1:0]        ALU_FUN;
    logic                         CLKG_EN;
    logic                         CLKDIV_EN;
    logic [D_WIDTH-1:0]           TX_DATA;
    logic                         TX_VLD;
    logic                         ERR;

    always #5 CLK = ~CLK;

    frame_cmd_ctrl #(
        .D_WIDTH     (D_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .FUNC_WIDTH  (FUNC_WIDTH),
        .RES_BYTES   (RES_BYTES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_DATA     (RX_DATA),
        .RX_VLD      (RX_VLD),
        .RF_RD_DATA  (RF_RD_DATA),
        .RF_RD_VLD   (RF_RD_VLD),
        .ALU_OUT     (ALU_OUT),
        .ALU_OUT_VLD (ALU_OUT_VLD),
        .FIFO_FULL   (FIFO_FULL),
        .RF_ADDR     (RF_ADDR),
        .RF_WR_EN    (RF_WR_EN),
        .RF_RD_EN    (RF_RD_EN),
        .RF_WR_DATA  (RF_WR_DATA),
        .ALU_EN      (ALU_EN),
        .ALU_FUN     (ALU_FUN),
        .CLKG_EN     (CLKG_EN),
        .CLKDIV_EN   (CLKDIV_EN),
        .TX_DATA     (TX_DATA),
        .TX_VLD      (TX_VLD),
        .ERR         (ERR)
    );

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int err_cnt = 0;

    logic [ADDR_WIDTH-1:0] wr_addr_q[$];
    logic [D_WIDTH-1:0]    wr_data_q[$];
    logic [D_WIDTH-1:0]    tx_q[$];
    int                    tx_cyc_q[$];

    int wr_base;
    int tx_base;
    int err_base;
    int drop_cyc;

    always @(posedge CLK) cyc <= cyc + 1;

    // Every high cycle of a strobe is logged, so a stretched pulse shows up
    // as an extra event.
    always @(negedge CLK) begin
        if (RF_WR_EN) begin
            wr_addr_q.push_back(RF_ADDR);
            wr_data_q.push_back(RF_WR_DATA);
        end
        if (TX_VLD) begin
            tx_q.push_back(TX_DATA);
            tx_cyc_q.push_back(cyc);
        end
        if (ERR) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic send(input logic [D_WIDTH-1:0] b);
        RX_DATA = b;
        RX_VLD  = 1'b1;
        step();
        RX_VLD  = 1'b0;
        RX_DATA = '0;
    endtask

    task automatic mark();
        wr_base  = wr_addr_q.size();
        tx_base  = tx_q.size();
        err_base = err_cnt;
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k = 0;
        while (((tx_q.size() - tx_base) < n) && (k < budget)) begin
            step();
            k++;
        end
    endtask

    task automatic check_wr(input string tag, input int idx,
                            input logic [ADDR_WIDTH-1:0] addr, input logic [D_WIDTH-1:0] data);
        if (wr_addr_q.size() > wr_base + idx) begin
            check({tag, "_addr"}, 32'(wr_addr_q[wr_base + idx]), 32'(addr));
            check({tag, "_data"}, 32'(wr_data_q[wr_base + idx]), 32'(data));
        end
    endtask

    task automatic check_tx(input string tag, input int idx, input logic [D_WIDTH-1:0] data);
        if (tx_q.size() > tx_base + idx)
            check(tag, 32'(tx_q[tx_base + idx]), 32'(data));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rf_addr"},   32'(RF_ADDR),    32'h0);
        check({tag, "_rf_wr_en"},  32'(RF_WR_EN),   32'h0);
        check({tag, "_rf_rd_en"},  32'(RF_RD_EN),   32'h0);
        check({tag, "_rf_wdata"},  32'(RF_WR_DATA), 32'h0);
        check({tag, "_alu_en"},    32'(ALU_EN),     32'h0);
        check({tag, "_alu_fun"},   32'(ALU_FUN),    32'h0);
        check({tag, "_clkg_en"},   32'(CLKG_EN),    32'h0);
        check({tag, "_clkdiv_en"}, 32'(CLKDIV_EN),  32'h1);
        check({tag, "_tx_data"},   32'(TX_DATA),    32'h0);
        check({tag, "_tx_vld"},    32'(TX_VLD),     32'h0);
        check({tag, "_err"},       32'(ERR),        32'h0);
    endtask

    initial begin
        // Reset state.
        step(2);
        check_reset_outputs("rst");
        RST = 1'b0;
        step(2);
        check("idle_clkdiv", 32'(CLKDIV_EN), 32'h1);
        check("idle_clkg",   32'(CLKG_EN),   32'h0);

        // Write frame AA,05,3C.
        mark();
        send(8'hAA);
        send(8'h05);
        send(8'h3C);
        step(2);
        check("wr_cnt", 32'(wr_addr_q.size() - wr_base), 32'd1);
        check_wr("wr", 0, 4'h5, 8'h3C);
        check("wr_pulse_end", 32'(RF_WR_EN), 32'h0);
        check("wr_err", 32'(err_cnt - err_base), 32'd0);

        // Read frame BB,05 with a stray byte in RD_WAIT and a full FIFO.
        mark();
        send(8'hBB);
        send(8'h05);
        check("rd_en",   32'(RF_RD_EN), 32'h1);
        check("rd_addr", 32'(RF_ADDR),  32'h5);
        send(8'hAA);
        check("rd_en_hold", 32'(RF_RD_EN), 32'h1);
        FIFO_FULL  = 1'b1;
        RF_RD_DATA = 8'h3C;
        RF_RD_VLD  = 1'b1;
        step();
        RF_RD_VLD  = 1'b0;
        check("rd_en_drop", 32'(RF_RD_EN), 32'h0);
        step(2);
        check("rd_tx_stall", 32'(tx_q.size() - tx_base), 32'd0);
        FIFO_FULL = 1'b0;
        drop_cyc  = cyc;
        wait_tx(1, 10);
        check("rd_tx_cnt", 32'(tx_q.size() - tx_base), 32'd1);
        check_tx("rd_tx_data", 0, 8'h3C);
        if (tx_cyc_q.size() > tx_base)
            check("rd_tx_cycle", 32'(tx_cyc_q[tx_base]), 32'(drop_cyc + 1));
        step(3);
        check("rd_no_wr",  32'(wr_addr_q.size() - wr_base), 32'd0);
        check("rd_no_err", 32'(err_cnt - err_base), 32'd0);
        check("rd_tx_once", 32'(tx_q.size() - tx_base), 32'd1);

        // ALU frame CC,10,20,01 with result 0x0030.
        mark();
        send(8'hCC);
        send(8'h10);
        send(8'h20);
        send(8'h01);
        check("alu_wr_cnt", 32'(wr_addr_q.size() - wr_base), 32'd2);
        check_wr("alu_opa", 0, 4'h0, 8'h10);
        check_wr("alu_opb", 1, 4'h1, 8'h20);
        check("alu_en",   32'(ALU_EN),  32'h1);
        check("alu_fun",  32'(ALU_FUN), 32'h1);
        check("alu_clkg", 32'(CLKG_EN), 32'h1);
        step(2);
        check("alu_en_hold", 32'(ALU_EN), 32'h1);
        ALU_OUT     = 16'h0030;
        ALU_OUT_VLD = 1'b1;
        step();
        ALU_OUT_VLD = 1'b0;
        check("alu_en_drop", 32'(ALU_EN), 32'h0);
        wait_tx(2, 10);
        check("alu_tx_cnt", 32'(tx_q.size() - tx_base), 32'd2);
        check_tx("alu_tx_lo", 0, 8'h30);
        check_tx("alu_tx_hi", 1, 8'h00);
        step(2);
        check("alu_clkg_off", 32'(CLKG_EN), 32'h0);

        // Timeout after AA,05: nothing before TIMEOUT_CYC cycles, then EE + ERR.
        mark();
        send(8'hAA);
        send(8'h05);
        step(TIMEOUT_CYC - 1);
        check("to_early_err", 32'(err_cnt - err_base), 32'd0);
        wait_tx(1, 10);
        check("to_tx_cnt", 32'(tx_q.size() - tx_base), 32'd1);
        check_tx("to_tx_data", 0, 8'hEE);
        step(2);
        check("to_err_cnt", 32'(err_cnt - err_base), 32'd1);
        check("to_no_wr",   32'(wr_addr_q.size() - wr_base), 32'd0);

        // A data byte landing exactly on the expiry cycle wins.
        mark();
        send(8'hAA);
        send(8'h06);
        step(TIMEOUT_CYC - 1);
        send(8'h77);
        step(2);
        check("edge_wr_cnt", 32'(wr_addr_q.size() - wr_base), 32'd1);
        check_wr("edge_wr", 0, 4'h6, 8'h77);
        check("edge_err", 32'(err_cnt - err_base), 32'd0);

        // Unknown command, then a DD,02 frame with a stalled result.
        mark();
        send(8'h77);
        wait_tx(1, 10);
        check_tx("bad_tx_data", 0, 8'hEE);
        step();
        check("bad_err_cnt", 32'(err_cnt - err_base), 32'd1);
        mark();
        send(8'hDD);
        send(8'h02);
        check("dd_alu_en",  32'(ALU_EN),  32'h1);
        check("dd_alu_fun", 32'(ALU_FUN), 32'h2);
        FIFO_FULL   = 1'b1;
        ALU_OUT     = 16'hA55A;
        ALU_OUT_VLD = 1'b1;
        step();
        ALU_OUT_VLD = 1'b0;
        step(2);
        check("dd_tx_stall", 32'(tx_q.size() - tx_base), 32'd0);
        check("dd_clkg",     32'(CLKG_EN), 32'h1);
        FIFO_FULL = 1'b0;
        wait_tx(2, 10);
        check("dd_tx_cnt", 32'(tx_q.size() - tx_base), 32'd2);
        check_tx("dd_tx_lo", 0, 8'h5A);
        check_tx("dd_tx_hi", 1, 8'hA5);
        check("dd_no_wr",  32'(wr_addr_q.size() - wr_base), 32'd0);
        check("dd_no_err", 32'(err_cnt - err_base), 32'd0);

        // Reset while in OPB aborts the frame.
        step(2);
        mark();
        send(8'hCC);
        send(8'h10);
        step();
        RST = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        step(2);
        RST = 1'b0;
        step(5);
        check("mid_wr_cnt", 32'(wr_addr_q.size() - wr_base), 32'd1);
        check_wr("mid_opa", 0, 4'h0, 8'h10);
        check("mid_no_tx",  32'(tx_q.size() - tx_base), 32'd0);
        check("mid_no_err", 32'(err_cnt - err_base), 32'd0);
        check("mid_alu_en", 32'(ALU_EN), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_cmd_ctrl.md
FRAME_CMD_CTRL -- requirements
Module: frame_cmd_ctrl

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8, meaning UART byte and register-file data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, meaning register-file address width; must satisfy ADDR_WIDTH <= D_WIDTH.
REQ-003 SHALL have parameter FUNC_WIDTH, default 4, meaning ALU function-code width; must satisfy FUNC_WIDTH <= D_WIDTH.
REQ-004 SHALL have parameter RES_BYTES, default 2, meaning ALU result width in bytes (ALU_OUT is RES_BYTES*D_WIDTH wide); must be >= 1.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1024, meaning the inter-byte timeout in CLK cycles; must be >= 2.
REQ-006 SHALL have one clock and an asynchronous, active-high reset.
REQ-007 Ports, in this order:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-high reset
- RX_DATA  in  D_WIDTH  received UART byte
- RX_VLD  in  1  one-cycle strobe qualifying RX_DATA
- RF_RD_DATA  in  D_WIDTH  register-file read data
- RF_RD_VLD  in  1  read data valid
- ALU_OUT  in  RES_BYTES*D_WIDTH  ALU result
- ALU_OUT_VLD  in  1  ALU result valid
- FIFO_FULL  in  1  TX FIFO full
- RF_ADDR  out  ADDR_WIDTH  register-file address
- RF_WR_EN  out  1  write strobe
- RF_RD_EN  out  1  read strobe
- RF_WR_DATA  out  D_WIDTH  write data
- ALU_EN  out  1  ALU enable
- ALU_FUN  out  FUNC_WIDTH  ALU function
- CLKG_EN  out  1  ALU clock-gate enable
- CLKDIV_EN  out  1  clock-divider enable
- TX_DATA  out  D_WIDTH  byte to the TX FIFO
- TX_VLD  out  1  TX FIFO write strobe
- ERR  out  1  one-cycle error pulse

Function
REQ-008 SHALL decode the commands 0xAA (write), 0xBB (read), 0xCC (ALU with operands) and 0xDD (ALU without operands); each code is zero-extended to D_WIDTH.
REQ-009 SHALL implement these states:
- IDLE
- WR_ADDR, WR_DATA (write)
- RD_ADDR, RD_WAIT (read)
- OPA, OPB, FUN, CALC (ALU)
- TX_RES (result transmit)
- ERR_TX (error report)
REQ-010 In IDLE, an RX_VLD byte SHALL select the next state:
- 0xAA -> WR_ADDR
- 0xBB -> RD_ADDR
- 0xCC -> OPA
- 0xDD -> FUN
- any other byte -> ERR_TX
REQ-011 In IDLE, a cycle without RX_VLD SHALL keep the block in IDLE.
REQ-012 Write command:
- WR_ADDR latches RX_DATA[ADDR_WIDTH-1:0] on RX_VLD, then goes to WR_DATA.
- WR_DATA, on RX_VLD, pulses RF_WR_EN for exactly 1 cycle, on the cycle after the data byte, with the latched address and data.
- The block then returns to IDLE.
REQ-013 Read command:
- RD_ADDR latches the address on RX_VLD, then goes to RD_WAIT.
- RD_WAIT holds RF_RD_EN high until RF_RD_VLD.
- The block then holds the read byte until FIFO_FULL=0, pulses TX_VLD for 1 cycle with TX_DATA = that byte, and returns to IDLE.
REQ-014 ALU command, operand phase:
- OPA writes RX_DATA to address 0 (RF_WR_EN pulse 1 cycle after the byte), then goes to OPB.
- OPB writes RX_DATA to address 1 the same way, then goes to FUN.
REQ-015 ALU command, function and calculate phase:
- FUN latches RX_DATA[FUNC_WIDTH-1:0], then goes to CALC.
- CALC holds ALU_EN=1 and ALU_FUN at the latched value until ALU_OUT_VLD.
- On ALU_OUT_VLD the block captures ALU_OUT, drops ALU_EN and goes to TX_RES.
REQ-016 TX_RES SHALL send RES_BYTES bytes, least-significant byte first, one byte per cycle when FIFO_FULL=0, and stall with TX_VLD=0 while FIFO_FULL=1; after the last byte it SHALL return to IDLE.
REQ-017 CLKG_EN SHALL be 1 in FUN, CALC and TX_RES, and 0 in all other states.
REQ-018 CLKDIV_EN SHALL be 1 in every state after reset.
REQ-019 Timeout:
- In WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB and FUN, a counter reloads on entry and on each RX_VLD.
- If TIMEOUT_CYC cycles pass without RX_VLD, the block goes to ERR_TX.
- RD_WAIT, CALC and TX_RES have no timeout.
REQ-020 ERR_TX SHALL wait for FIFO_FULL=0, then in one cycle pulse TX_VLD with TX_DATA=0xEE (zero-extended) and pulse ERR; it SHALL then return to IDLE.
REQ-021 A partially received command SHALL never produce an RF write for an incomplete frame.
REQ-022 When RX_VLD arrives in the same cycle as a timeout expiry, the byte SHALL win and the timeout SHALL be ignored.
REQ-023 RX_VLD arriving in RD_WAIT, CALC, TX_RES or ERR_TX SHALL be ignored.
REQ-024 All outputs SHALL be registered; TX_VLD, RF_WR_EN and ERR SHALL be single-cycle pulses per event.

Reset
REQ-025 While RST=1, the block SHALL be in IDLE, with:
- all enables, strobes and ERR = 0
- CLKDIV_EN = 1
- RF_ADDR, RF_WR_DATA, ALU_FUN, TX_DATA = 0
- the timeout counter and byte index = 0
REQ-026 Asserting RST mid-frame SHALL abort the frame with no further RF or TX activity after the reset is released.

Structure
REQ-027 A shared package SHALL hold:
- the state enumeration
- the command codes 0xAA, 0xBB, 0xCC, 0xDD
- the error code 0xEE
REQ-028 The timeout counter SHALL be a sub-module named cmd_timeout, with inputs clear and enable and an expired output.

Verification
REQ-029 Write: frame AA,05,3C -> one RF_WR_EN pulse with RF_ADDR=5 and RF_WR_DATA=0x3C, then IDLE.
REQ-030 Read: frame BB,05; RF returns 0x3C; FIFO_FULL=1 for 3 cycles -> TX_VLD asserts only after FIFO_FULL drops, with TX_DATA=0x3C.
REQ-031 ALU with RES_BYTES=2: frame CC,10,20,01; ALU_OUT=0x0030 -> RF writes addr0=0x10 and addr1=0x20, ALU_FUN=1, then TX bytes 0x30, 0x00.
REQ-032 Timeout: frame AA,05, then silence for TIMEOUT_CYC cycles -> TX 0xEE, one ERR pulse, no RF write.
REQ-033 Unknown command 0x77 -> TX 0xEE and ERR; a following DD,02 frame is processed normally.
REQ-034 RST asserted in OPB -> no RF write for address 1, and all outputs at their REQ-025 reset values.
